// File: rtl/fb_pkg.sv
// Shared constants and FSM state encoding for the framebuffer fill engine.
package fb_pkg;

   localparam int FB_H_RES = 640;
   localparam int FB_V_RES = 480;

   typedef logic [1:0] fill_state_t;

   localparam fill_state_t ST_IDLE = 2'd0;
   localparam fill_state_t ST_FILL = 2'd1;
   localparam fill_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/framebuffer_fill_engine_if.sv
// Framebuffer write port: the engine drives the request, the memory answers with ready.
interface framebuffer_fill_engine_if #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 19
);

   logic                  mem_we;
   logic                  mem_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;

   modport master (output mem_we, mem_addr, mem_data, input mem_ready);
   modport slave  (input mem_we, mem_addr, mem_data, output mem_ready);

endinterface

// File: rtl/fill_addr_gen.sv
// Raster-order x/y walker producing the framebuffer address by incremental adds.
module fill_addr_gen
   import fb_pkg::*;
#(
   parameter int ADDR_WIDTH = 19,
   parameter int H_RES      = FB_H_RES,
   parameter int XW         = 10,
   parameter int YW         = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic [XW-1:0]         x0,
   input  logic [XW-1:0]         x1,
   input  logic [YW-1:0]         y0,
   input  logic [YW-1:0]         y1,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last
);

   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(H_RES);

   logic [XW-1:0]         x_q;
   logic [XW-1:0]         x0_q;
   logic [XW-1:0]         x1_q;
   logic [YW-1:0]         y_q;
   logic [YW-1:0]         y1_q;
   logic [ADDR_WIDTH-1:0] row_base_q;
   logic [ADDR_WIDTH-1:0] addr_q;

   // The one multiply happens once per fill at load; pixel steps only add.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q        <= '0;
         x0_q       <= '0;
         x1_q       <= '0;
         y_q        <= '0;
         y1_q       <= '0;
         row_base_q <= '0;
         addr_q     <= '0;
      end else if (load) begin
         x0_q       <= x0;
         x1_q       <= x1;
         y1_q       <= y1;
         x_q        <= x0;
         y_q        <= y0;
         row_base_q <= ADDR_WIDTH'(y0) * ROW_STEP;
         addr_q     <= ADDR_WIDTH'(y0) * ROW_STEP + ADDR_WIDTH'(x0);
      end else if (step) begin
         if (x_q == x1_q) begin
            x_q        <= x0_q;
            y_q        <= y_q + 1'b1;
            row_base_q <= row_base_q + ROW_STEP;
            addr_q     <= row_base_q + ROW_STEP + ADDR_WIDTH'(x0_q);
         end else begin
            x_q    <= x_q + 1'b1;
            addr_q <= addr_q + 1'b1;
         end
      end
   end

   assign addr = addr_q;
   assign last = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/framebuffer_fill_engine.sv
// Fills an inclusive rectangle of the framebuffer with one pixel value, one write per accepted cycle.
//   state   | meaning
//   IDLE    | waiting for start; bad requests pulse err
//   FILL    | mem_we held high, address steps on each accepted write
//   DONE    | one-cycle done pulse, then back to IDLE
module framebuffer_fill_engine
   import fb_pkg::*;
#(
   parameter int  DATA_WIDTH = 1,
   parameter int  ADDR_WIDTH = 19,
   parameter int  H_RES      = FB_H_RES,
   parameter int  V_RES      = FB_V_RES,
   localparam int XW         = $clog2(H_RES),
   localparam int YW         = $clog2(V_RES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic [DATA_WIDTH-1:0]     fill_data,
   input  logic [XW-1:0]             x0,
   input  logic [XW-1:0]             x1,
   input  logic [YW-1:0]             y0,
   input  logic [YW-1:0]             y1,
   framebuffer_fill_engine_if.master mem,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam logic [XW:0] X_LIM = (XW+1)'(H_RES);
   localparam logic [YW:0] Y_LIM = (YW+1)'(V_RES);

   fill_state_t           state;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ADDR_WIDTH-1:0] gen_addr;
   logic                  req_ok;
   logic                  accept;
   logic                  load;
   logic                  step;
   logic                  last;

   assign req_ok = (x0 <= x1) && ({1'b0, x1} < X_LIM) &&
                   (y0 <= y1) && ({1'b0, y1} < Y_LIM);
   assign accept = we_q & mem.mem_ready;
   assign load   = (state == ST_IDLE) && start && req_ok;
   // Abort wins over a final accept; the generator simply stops where it is.
   assign step   = (state == ST_FILL) && accept && !abort && !last;

   fill_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .H_RES      (H_RES),
      .XW         (XW),
      .YW         (YW)
   ) u_addr_gen (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .step (step),
      .x0   (x0),
      .x1   (x1),
      .y0   (y0),
      .y1   (y1),
      .addr (gen_addr),
      .last (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         we_q   <= 1'b0;
         data_q <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (req_ok) begin
                     state  <= ST_FILL;
                     we_q   <= 1'b1;
                     busy   <= 1'b1;
                     data_q <= fill_data;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_FILL: begin
               if (abort) begin
                  state <= ST_IDLE;
                  we_q  <= 1'b0;
                  busy  <= 1'b0;
               end else if (accept && last) begin
                  state <= ST_DONE;
                  we_q  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               we_q  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign mem.mem_we   = we_q;
   assign mem.mem_addr = gen_addr;
   assign mem.mem_data = data_q;

endmodule

// File: doc/framebuffer_fill_engine.md
FRAMEBUFFER_FILL_ENGINE -- requirements
Module: framebuffer_fill_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, pixel data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 19, framebuffer address width in bits.
REQ-003 SHALL have parameter H_RES, default 640, framebuffer width in pixels.
REQ-004 SHALL have parameter V_RES, default 480, framebuffer height in pixels; XW = clog2(H_RES), YW = clog2(V_RES).
REQ-005 SHALL have port clk, input, 1, clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port start, input, 1, request a fill; sampled only in IDLE.
REQ-008 SHALL have port abort, input, 1, cancel an in-progress fill.
REQ-009 SHALL have port fill_data, input, DATA_WIDTH, pixel value to write.
REQ-010 SHALL have ports x0 and x1, input, XW each, inclusive column bounds.
REQ-011 SHALL have ports y0 and y1, input, YW each, inclusive row bounds.
REQ-012 SHALL have port mem_ready, input, 1, memory accepts the current write.
REQ-013 SHALL have port mem_we, output, 1, write request.
REQ-014 SHALL have port mem_addr, output, ADDR_WIDTH, write address.
REQ-015 SHALL have port mem_data, output, DATA_WIDTH, write data.
REQ-016 SHALL have port busy, output, 1, high while a fill is in progress.
REQ-017 SHALL have port done, output, 1, one-cycle pulse on normal completion.
REQ-018 SHALL have port err, output, 1, one-cycle pulse when a start is rejected.

Function
REQ-019 SHALL implement the states IDLE, FILL and DONE.
REQ-020 SHALL, in IDLE when start=1, latch fill_data, x0, x1, y0 and y1, then check that x0<=x1<H_RES and y0<=y1<V_RES.
REQ-021 SHALL, on a valid request, enter FILL on the next edge, with mem_we=1, mem_addr=y0*H_RES+x0 and busy=1 in that first cycle.
REQ-022 SHALL, on an invalid request, pulse err for one cycle, stay in IDLE and never assert mem_we.
REQ-023 SHALL treat a write as accepted only when mem_we=1 and mem_ready=1 in the same cycle.
REQ-024 SHALL hold mem_addr and mem_data stable while mem_we=1 and mem_ready=0.
REQ-025 SHALL advance in raster order on each accepted write: x increments; at x==x1, x returns to x0, y increments and row_base increases by H_RES.
REQ-026 SHALL form mem_addr as row_base+x using incremental addition only (no multiplier in the per-pixel path).
REQ-027 SHALL accept one write per cycle when mem_ready is held high.
REQ-028 SHALL, on acceptance of the last pixel (x==x1, y==y1), go to DONE with mem_we=0; done=1 for one cycle, then IDLE.
REQ-029 SHALL, on abort=1 in FILL, return to IDLE at the next edge with mem_we=0 and busy=0, and no done pulse; a write accepted in that same cycle counts as completed.
REQ-030 SHALL ignore start while in FILL or DONE.
REQ-031 SHALL keep busy=1 in FILL and DONE, and busy=0 in IDLE.
REQ-032 SHALL, for a single-pixel region (x0==x1, y0==y1), issue exactly one write, then pulse done.
REQ-033 SHALL, for a full-frame region, issue exactly H_RES*V_RES writes, with addresses 0 to H_RES*V_RES-1 in order.

Reset
REQ-034 SHALL, when rst=1, force state=IDLE, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, err=0 and clear all internal counters, regardless of state, including mid-fill.
REQ-035 SHALL, after rst is released, start no write until a new valid start is received.

Structure
REQ-036 SHALL place the FSM state enumeration and the default H_RES/V_RES constants in shared package fb_pkg.
REQ-037 SHALL implement the x/y counters, row_base register and address adder in sub-module fill_addr_gen, with a step/load interface and a last flag.
REQ-038 SHALL register all outputs, with no combinational path from any input to mem_we, mem_addr or mem_data.

Verification
REQ-039 SHALL test a full clear: defaults, region 0..639 x 0..479, data=0, mem_ready=1 -> 307200 writes to addresses 0..307199 in order, done one cycle after the last write, busy low one cycle after done.
REQ-040 SHALL test a rectangle: x 10..12, y 5..6 -> addresses 3210, 3211, 3212, 3850, 3851, 3852, then a single done pulse.
REQ-041 SHALL test backpressure: mem_ready toggled pseudo-randomly -> the same address sequence, mem_addr/mem_data stable during stalls, write count equal to the region size.
REQ-042 SHALL test rejection: x0=20, x1=10 -> err for one cycle, mem_we never high, busy stays 0; likewise for y1=480.
REQ-043 SHALL test abort and restart: abort after 100 accepted writes -> mem_we low next cycle, no done; a new start then fills correctly from its own (x0,y0).
REQ-044 SHALL test reset mid-fill: rst asserted during FILL -> all outputs 0 immediately (asynchronously); a following single-pixel fill (x=639, y=479) writes address 307199, then pulses done.
